result_store_writer: RTL and testbench
======================================

Name: result_store_writer

Overview:
- Consumer side of the output buffer's 17-bit store path.
- Captures one parallel beat of LANES x 17-bit results (output buffer `store_data_17_o`) on `start`.
- Serialises the beat into PACK-lane memory words and writes them to the feature-map BRAM port under a valid/ready handshake.
- Sits between the output buffer and the next layer's feature-map memory; driven by the top-level control FSM.

Parameters:
- LANES, 112, number of 17-bit lanes in one captured beat (matches MAC_NUM).
- PACK, 4, lanes packed per memory word.
- ADDR_W, 12, memory address width.
- CNT_W, 7, width of lane-count input and internal lane index (must hold LANES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request; capture inputs, begin writing.
- store_data_17  in  LANES*17  lane data; lane i at bits [i*17 +: 17], two's complement.
- valid_lanes  in  CNT_W  number of lanes to write, starting at lane 0.
- base_addr  in  ADDR_W  address of first word.
- mem_ready  in  1  memory accepts the current word this cycle.
- mem_we  out  1  word valid; held until accepted.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  PACK*17  packed lanes; lowest lane in bits [16:0].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the last word is accepted.

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst).
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; state=IDLE; lane index=0.
- States: IDLE, WRITE, DONE.
- IDLE, start=1:
  - Latch store_data_17 into the shadow register.
  - Latch n = min(valid_lanes, LANES) and base_addr.
  - Go to WRITE if n>0, else DONE.
  - busy=1 from the next cycle.
- WRITE:
  - mem_we=1.
  - mem_wdata = shadow lanes [idx .. idx+PACK-1]; lanes >= n drive 0.
  - mem_addr = base_addr + idx/PACK, modulo 2^ADDR_W (wrap permitted).
  - On mem_we & mem_ready: idx += PACK.
  - If idx+PACK >= n: go to DONE, mem_we=0 next cycle.
  - mem_addr and mem_wdata are stable while mem_we=1 and mem_ready=0.
- Word count = ceil(n/PACK). The first word is presented the cycle after start.
- Minimum latency, start to done: ceil(n/PACK)+1 cycles with mem_ready held high.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
  - A start arriving in DONE is ignored.
- start while busy (WRITE/DONE): ignored; the shadow register is unchanged.
- The shadow register decouples the block from the output buffer. Upstream may change store_data_17 immediately after start.
- rst asserted mid-WRITE: the block immediately returns to the reset values. No done pulse; the partial write is abandoned.
- mem_ready is ignored while mem_we=0.

Optional Feature:
- RESULT_STORE_RELU_EN.
- Defined: at capture, any lane with bit16=1 is stored as 17'h0 (ReLU before the next layer).
- Undefined: lanes are stored unmodified.
- Timing and handshake are identical in both cases.

Test Plan:
- Full beat: LANES=112, valid_lanes=112, base_addr=0x010, mem_ready=1, lane i = i.
  - Expect 28 writes at 0x010..0x02B; word 0 = {17'd3,17'd2,17'd1,17'd0}.
  - Expect done 29 cycles after start.
- Partial last word: valid_lanes=10.
  - Expect 3 writes.
  - Third word: lanes 8,9 in low 34 bits; upper 34 bits zero.
- Backpressure: toggle mem_ready 1,0,0,1,...
  - mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
  - No word is duplicated or skipped; done follows the last acceptance.
- Edge cases:
  - valid_lanes=0: no mem_we; done pulses the cycle after start.
  - valid_lanes=127: clamps to 112, giving 28 writes.
  - base_addr=0xFFE, 4 words: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Robustness:
  - Second start during WRITE, with store_data_17 changed: ignored; output data is from the first capture.
  - rst asserted after 5 accepted words: outputs return to 0 that cycle; no done.
  - A later start then works normally.
- RELU: with RESULT_STORE_RELU_EN defined, lane 0 = 17'h1FFFF is written as 0 and lane 1 = 17'h00005 as 5. Without it, both are unchanged.

Source files
------------

// File: rtl/result_store_writer.sv
// Captures one LANES x 17-bit result beat and streams it as PACK-lane words to feature-map memory.
// Optional: define RESULT_STORE_RELU_EN to zero negative lanes at capture time.
module result_store_writer #(
  parameter int LANES  = 112,
  parameter int PACK   = 4,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LANES*17-1:0]   store_data_17,
  input  logic [CNT_W-1:0]      valid_lanes,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [PACK*17-1:0]    mem_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int LANE_W    = 17;
  localparam int WORD_W    = PACK * LANE_W;
  localparam int NUM_WORDS = (LANES + PACK - 1) / PACK;
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_WORDS*WORD_W-1:0] capture_flat;
  logic [WORD_W-1:0]           shadow_reg [NUM_WORDS];
  logic [WORD_W-1:0]           masked_word;
  logic [CNT_W-1:0]            n_reg;
  logic [CNT_W-1:0]            n_clamped;
  logic [ADDR_W-1:0]           base_reg;
  logic [CNT_W-1:0]            idx_reg;
  logic [WIDX_W-1:0]           word_idx_reg;
  logic [CNT_W:0]              idx_plus;
  logic                        start_ok;
  logic                        accept;
  logic                        last_word;

  assign n_clamped = (valid_lanes > LANES_C) ? LANES_C : valid_lanes;
  assign start_ok  = (state_reg == IDLE) && start;
  assign accept    = (state_reg == WRITE) && mem_ready;
  assign idx_plus  = {1'b0, idx_reg} + (CNT_W+1)'(PACK);
  assign last_word = idx_plus >= {1'b0, n_reg};

  // Capture path: lanes are regrouped into memory words; the tail of the last word is zero padded.
  genvar gi, gp;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      for (gp = 0; gp < PACK; gp++) begin : g_lane
        localparam int LANE = gi * PACK + gp;
        if (LANE < LANES) begin : g_live
          logic [LANE_W-1:0] raw;
          assign raw = store_data_17[LANE*LANE_W +: LANE_W];
`ifdef RESULT_STORE_RELU_EN
          assign capture_flat[(gi*WORD_W + gp*LANE_W) +: LANE_W] = raw[LANE_W-1] ? '0 : raw;
`else
          assign capture_flat[(gi*WORD_W + gp*LANE_W) +: LANE_W] = raw;
`endif
        end else begin : g_pad
          assign capture_flat[(gi*WORD_W + gp*LANE_W) +: LANE_W] = '0;
        end
      end
    end
  endgenerate

  // Shadow copy lets upstream move on right after start; only loaded on an accepted start.
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (start_ok) begin
          shadow_reg[gi] <= capture_flat[gi*WORD_W +: WORD_W];
        end
      end
    end
  endgenerate

  // Lanes at or beyond the requested count are blanked in the outgoing word.
  generate
    for (gp = 0; gp < PACK; gp++) begin : g_mask
      logic [CNT_W:0]  lane_num;
      logic [WORD_W-1:0] sel_word;
      assign sel_word = shadow_reg[word_idx_reg];
      assign lane_num = {1'b0, idx_reg} + (CNT_W+1)'(gp);
      assign masked_word[gp*LANE_W +: LANE_W] =
        (lane_num < {1'b0, n_reg}) ? sel_word[gp*LANE_W +: LANE_W] : '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg        <= '0;
      base_reg     <= '0;
      idx_reg      <= '0;
      word_idx_reg <= '0;
    end else if (start_ok) begin
      n_reg        <= n_clamped;
      base_reg     <= base_addr;
      idx_reg      <= '0;
      word_idx_reg <= '0;
    end else if (accept) begin
      idx_reg      <= idx_plus[CNT_W-1:0];
      word_idx_reg <= word_idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (n_clamped == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (accept && last_word) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so they drop to zero as soon as rst asserts.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_reg)
      WRITE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        mem_addr  = base_reg + ADDR_W'(word_idx_reg);
        mem_wdata = masked_word;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_result_store_writer.sv
// Directed self-checking bench for result_store_writer (honours RESULT_STORE_RELU_EN when defined).
module tb_result_store_writer;

  localparam int LANES  = 112;
  localparam int PACK   = 4;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 7;
  localparam int WORD_W = PACK * 17;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [LANES*17-1:0]   store_data_17;
  logic [CNT_W-1:0]      valid_lanes;
  logic [ADDR_W-1:0]     base_addr;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  logic [16:0]       tb_lane  [LANES];
  logic [ADDR_W-1:0] acc_addr [64];
  logic [WORD_W-1:0] acc_data [64];
  int                acc_n;
  int                done_cyc;
  int                last_acc_cyc;

  result_store_writer #(
    .LANES (LANES),
    .PACK  (PACK),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .store_data_17(store_data_17),
    .valid_lanes  (valid_lanes),
    .base_addr    (base_addr),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] relu(input logic [16:0] v);
`ifdef RESULT_STORE_RELU_EN
    return v[16] ? 17'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(input int k, input int n);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int p = 0; p < PACK; p++) begin
      if (k * PACK + p < n) w[p*17 +: 17] = relu(tb_lane[k*PACK+p]);
    end
    return w;
  endfunction

  task automatic drive_lanes(input bit invert);
    for (int i = 0; i < LANES; i++) begin
      store_data_17[i*17 +: 17] = invert ? ~tb_lane[i] : tb_lane[i];
    end
  endtask

  // One transaction: issue start, then watch every cycle until done (bounded).
  task automatic run_txn(input int vl, input logic [ADDR_W-1:0] base, input int n_eff,
                         input int exp_words, input bit bp, input bit poke, input string name);
    int cyc;
    int step;
    bit stalled;
    bit done_seen;
    logic [ADDR_W-1:0] prev_addr;
    logic [WORD_W-1:0] prev_data;
    logic [ADDR_W-1:0] ea;
    acc_n = 0; done_cyc = -1; last_acc_cyc = 0; step = 0; stalled = 0; done_seen = 0;
    prev_addr = '0; prev_data = '0;
    @(negedge clk);
    check({name, " idle busy"}, busy, 1'b0);
    valid_lanes = CNT_W'(vl);
    base_addr   = base;
    drive_lanes(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_lanes(1'b1);
    cyc = 1;
    while (!done_seen && cyc <= 200) begin
      if (cyc == 1 && exp_words > 0) begin
        check({name, " busy after start"}, busy, 1'b1);
        check({name, " first word next cycle"}, mem_we, 1'b1);
      end
      if (poke) begin
        if (cyc == 3) begin
          start = 1'b1; valid_lanes = 7'd5; base_addr = 12'h777;
        end else if (cyc == 4) begin
          start = 1'b0;
        end
      end
      if (mem_we) begin
        if (stalled) begin
          check({name, " stall addr stable"}, mem_addr, prev_addr);
          check({name, " stall data stable"}, mem_wdata, prev_data);
        end
        ea = base + ADDR_W'(acc_n);
        check({name, " addr"}, mem_addr, ea);
        check({name, " data"}, mem_wdata, exp_word(acc_n, n_eff));
        mem_ready = bp ? (step % 3 == 0) : 1'b1;
        step++;
        if (mem_ready) begin
          acc_addr[acc_n] = mem_addr;
          acc_data[acc_n] = mem_wdata;
          acc_n++;
          last_acc_cyc = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          prev_addr = mem_addr;
          prev_data = mem_wdata;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        check({name, " busy low in done"}, busy, 1'b0);
        check({name, " no we in done"}, mem_we, 1'b0);
        if (poke) start = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, " done seen"}, done_seen, 1'b1);
    check({name, " word count"}, acc_n, exp_words);
    check({name, " done after last accept"}, done_cyc, last_acc_cyc + 1);
    check({name, " done single pulse"}, done, 1'b0);
    check({name, " idle after done"}, {mem_we, busy}, 2'b00);
    $display("txn %s: words=%0d done_cycle=%0d", name, acc_n, done_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_we;
    int cnt_done;
    rst = 1'b1; start = 1'b0; valid_lanes = '0; base_addr = '0; mem_ready = 1'b0;
    store_data_17 = '0;
    for (int i = 0; i < LANES; i++) tb_lane[i] = 17'(i);
    repeat (2) @(negedge clk);
    check("reset mem_we", mem_we, 1'b0);
    check("reset mem_addr", mem_addr, 12'h000);
    check("reset mem_wdata", mem_wdata, 68'h0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    rst = 1'b0;

    run_txn(112, 12'h010, 112, 28, 1'b0, 1'b0, "full");
    check("full word0", acc_data[0], {17'd3, 17'd2, 17'd1, 17'd0});
    check("full first addr", acc_addr[0], 12'h010);
    check("full last addr", acc_addr[27], 12'h02B);
    check("full done latency", done_cyc, 29);

    run_txn(10, 12'h100, 10, 3, 1'b0, 1'b0, "partial");
    check("partial word2 upper", acc_data[2][67:34], 34'h0);
    check("partial word2 lower", acc_data[2][33:0], {17'd9, 17'd8});

    run_txn(37, 12'h200, 37, 10, 1'b1, 1'b0, "backpressure");
    check("backpressure last addr", acc_addr[9], 12'h209);
    check("backpressure last word", acc_data[9], {17'd0, 17'd0, 17'd0, 17'd36});

    run_txn(0, 12'h300, 0, 0, 1'b0, 1'b0, "zero");
    check("zero done latency", done_cyc, 1);

    run_txn(127, 12'h000, 112, 28, 1'b0, 1'b0, "clamp");
    check("clamp last addr", acc_addr[27], 12'h01B);

    run_txn(16, 12'hFFE, 16, 4, 1'b0, 1'b0, "wrap");
    check("wrap addr0", acc_addr[0], 12'hFFE);
    check("wrap addr1", acc_addr[1], 12'hFFF);
    check("wrap addr2", acc_addr[2], 12'h000);
    check("wrap addr3", acc_addr[3], 12'h001);

    run_txn(112, 12'h040, 112, 28, 1'b0, 1'b1, "restart");
    check("restart word5", acc_data[5], {17'd23, 17'd22, 17'd21, 17'd20});

    // Reset in the middle of a write burst.
    @(negedge clk);
    valid_lanes = 7'd112; base_addr = 12'h080; drive_lanes(1'b0); start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst addr before rst", mem_addr, 12'h085);
    rst = 1'b1;
    #1;
    check("midrst mem_we", mem_we, 1'b0);
    check("midrst mem_addr", mem_addr, 12'h000);
    check("midrst mem_wdata", mem_wdata, 68'h0);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cnt_we = 0; cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_we) cnt_we++;
      if (done) cnt_done++;
    end
    check("midrst no resume", cnt_we, 0);
    check("midrst no done", cnt_done, 0);
    $display("txn midrst: abandoned after 5 words");

    run_txn(10, 12'h500, 10, 3, 1'b0, 1'b0, "after_rst");
    check("after_rst word0", acc_data[0], {17'd3, 17'd2, 17'd1, 17'd0});

    tb_lane[0] = 17'h1FFFF;
    tb_lane[1] = 17'h00005;
    run_txn(2, 12'h600, 2, 1, 1'b0, 1'b0, "relu");
`ifdef RESULT_STORE_RELU_EN
    check("relu lane0", acc_data[0][16:0], 17'h00000);
`else
    check("relu lane0", acc_data[0][16:0], 17'h1FFFF);
`endif
    check("relu lane1", acc_data[0][33:17], 17'h00005);
    check("relu upper", acc_data[0][67:34], 34'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
